// File: rtl/block_initiator_pkg.sv
// Shared types and constants for the cache storage block initiator.
// Retry behaviour is selected by BLOCK_INITIATOR_RETRY_EN.
package block_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int BLK_DATA_WIDTH = 16;
    localparam int BLK_MAX_RETRY  = 2;
endpackage

// File: rtl/block_initiator_if.sv
// Controller request/response port plus storage block bus.
// Master is the initiator side, slave is controller plus block.
interface block_initiator_if
    import block_pkg::*;
#(
    parameter int DATA_WIDTH = BLK_DATA_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [0:DATA_WIDTH-1] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [0:DATA_WIDTH-1] rsp_data;
    logic                  rsp_error;
    logic                  blk_enable;
    logic                  blk_write;
    logic [0:DATA_WIDTH-1] blk_data_in;
    logic [0:DATA_WIDTH-1] blk_data_out;
    logic                  blk_ack;

    modport master (
        input  req_valid, req_write, req_data,
        input  rsp_ready, blk_data_out, blk_ack,
        output req_ready, rsp_valid, rsp_data,
        output rsp_error, blk_enable, blk_write,
        output blk_data_in
    );

    modport slave (
        output req_valid, req_write, req_data,
        output rsp_ready, blk_data_out, blk_ack,
        input  req_ready, rsp_valid, rsp_data,
        input  rsp_error, blk_enable, blk_write,
        input  blk_data_in
    );
endinterface

// File: rtl/block_initiator_timer.sv
// 8-bit saturating counter; hit flags the edge on which the
// count reaches limit. Shared by the cache engines.
module block_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] limit,
    output logic       hit
);
    logic [7:0] cnt_q;
    logic [7:0] nxt;

    assign nxt = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign hit = en && (nxt >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (en) begin
            cnt_q <= nxt;
        end
    end
endmodule

// File: rtl/block_initiator.sv
// Single-outstanding requester for a cache storage block.
// BLOCK_INITIATOR_RETRY_EN re-issues timed-out requests twice.
module block_initiator
    import block_pkg::*;
#(
    parameter int DATA_WIDTH     = BLK_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    block_initiator_if.master  bus
);
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_t                state;
    logic                  wr_q;
    logic                  hit;
    logic [0:DATA_WIDTH-1] rdata;
`ifdef BLOCK_INITIATOR_RETRY_EN
    logic [1:0]            retry;
`endif

    assign rdata = wr_q ? '0 : bus.blk_data_out;

    block_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != WAIT),
        .en    ((state == WAIT) && !bus.blk_ack),
        .limit (TMO),
        .hit   (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wr_q            <= 1'b0;
            bus.req_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_error   <= 1'b0;
            bus.blk_enable  <= 1'b0;
            bus.blk_write   <= 1'b0;
            bus.blk_data_in <= '0;
`ifdef BLOCK_INITIATOR_RETRY_EN
            retry           <= 2'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state           <= ISSUE;
                        wr_q            <= bus.req_write;
                        bus.req_ready   <= 1'b0;
                        bus.blk_enable  <= 1'b1;
                        bus.blk_write   <= bus.req_write;
                        bus.blk_data_in <= bus.req_data;
`ifdef BLOCK_INITIATOR_RETRY_EN
                        retry           <= 2'd0;
`endif
                    end
                end
                ISSUE, WAIT: begin
                    bus.blk_write <= 1'b0;
                    if (bus.blk_ack) begin
                        state           <= RESP;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_error   <= 1'b0;
                        bus.rsp_data    <= rdata;
                        bus.blk_enable  <= 1'b0;
                        bus.blk_data_in <= '0;
                    end else if ((state == WAIT) && hit) begin
`ifdef BLOCK_INITIATOR_RETRY_EN
                        if (retry < 2'(BLK_MAX_RETRY)) begin
                            retry         <= retry + 2'd1;
                            state         <= ISSUE;
                            bus.blk_write <= wr_q;
                        end else
`endif
                        begin
                            state           <= RESP;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_error   <= 1'b1;
                            bus.rsp_data    <= '0;
                            bus.blk_enable  <= 1'b0;
                            bus.blk_data_in <= '0;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_data  <= '0;
                        bus.rsp_error <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_initiator.sv
// Directed bench for block_initiator with a response scoreboard.
// Honours BLOCK_INITIATOR_RETRY_EN when the design is built with it.
module tb_block_initiator;
    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } rsp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_wr = 0;
    int   n_en = 0;
    rsp_t sb[$];

    block_initiator_if bus ();

    block_initiator #(
        .DATA_WIDTH     (16),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.blk_write)  n_wr++;
        if (bus.blk_enable) n_en++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic e);
        rsp_t r;
        r.d = d;
        r.e = e;
        sb.push_back(r);
    endtask

    task automatic collect(input string tag, input int budget);
        rsp_t r;
        int   i;
        i = 0;
        while (!bus.rsp_valid && i < budget) begin
            step();
            i++;
        end
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (bus.rsp_valid && sb.size() > 0) begin
            r = sb.pop_front();
            check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(r.d));
            check({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'(r.e));
        end
    endtask

    task automatic request(input logic w, input logic [15:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_data  = d;
    endtask

    initial begin
        int wr0;
        int en0;
        int exp_wr;
        int exp_en;

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_data     = '0;
        bus.rsp_ready    = 1'b1;
        bus.blk_data_out = '0;
        bus.blk_ack      = 1'b0;
        step();
        step();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        check("rst_blk_enable", 32'(bus.blk_enable), 32'd0);
        check("rst_blk_write", 32'(bus.blk_write), 32'd0);
        check("rst_blk_data_in", 32'(bus.blk_data_in), 32'd0);
        rst = 1'b0;
        step();

        // write, ack two cycles after enable
        wr0 = n_wr;
        en0 = n_en;
        bus.blk_data_out = 16'hFFFF;
        request(1'b1, 16'h0F0F);
        push(16'h0000, 1'b0);
        step();
        bus.req_valid = 1'b0;
        check("wr_enable", 32'(bus.blk_enable), 32'd1);
        check("wr_strobe", 32'(bus.blk_write), 32'd1);
        check("wr_data_in", 32'(bus.blk_data_in), 32'h0F0F);
        check("wr_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        check("wr_strobe_drop", 32'(bus.blk_write), 32'd0);
        check("wr_data_hold", 32'(bus.blk_data_in), 32'h0F0F);
        bus.blk_ack = 1'b1;
        collect("wr", 10);
        bus.blk_ack = 1'b0;
        step();
        check("wr_pulses", 32'(n_wr - wr0), 32'd1);
        check("wr_en_cycles", 32'(n_en - en0), 32'd2);
        check("wr_back_idle", 32'(bus.req_ready), 32'd1);

        // read
        wr0 = n_wr;
        request(1'b0, 16'h1111);
        push(16'hA5C3, 1'b0);
        step();
        bus.req_valid = 1'b0;
        step();
        bus.blk_data_out = 16'hA5C3;
        bus.blk_ack = 1'b1;
        collect("rd", 10);
        bus.blk_ack = 1'b0;
        step();
        check("rd_no_strobe", 32'(n_wr - wr0), 32'd0);

        // ack during the ISSUE cycle
        en0 = n_en;
        request(1'b0, 16'h0000);
        push(16'h1234, 1'b0);
        step();
        bus.req_valid = 1'b0;
        bus.blk_data_out = 16'h1234;
        bus.blk_ack = 1'b1;
        step();
        check("fast_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        collect("fast", 0);
        bus.blk_ack = 1'b0;
        step();
        check("fast_en_cycles", 32'(n_en - en0), 32'd1);

        // timeout with no ack
        wr0 = n_wr;
        en0 = n_en;
        request(1'b1, 16'h3C3C);
        push(16'h0000, 1'b1);
        step();
        bus.req_valid = 1'b0;
        collect("tmo", 60);
        step();
`ifdef BLOCK_INITIATOR_RETRY_EN
        exp_wr = 3;
        exp_en = 15;
`else
        exp_wr = 1;
        exp_en = 5;
`endif
        check("tmo_pulses", 32'(n_wr - wr0), 32'(exp_wr));
        check("tmo_en_cycles", 32'(n_en - en0), 32'(exp_en));

        // backpressure; second request ignored until after rsp_ready
        bus.rsp_ready = 1'b0;
        request(1'b0, 16'h0000);
        push(16'hBEEF, 1'b0);
        step();
        bus.req_valid = 1'b0;
        bus.blk_data_out = 16'hBEEF;
        bus.blk_ack = 1'b1;
        step();
        bus.blk_ack = 1'b0;
        bus.blk_data_out = 16'h0000;
        collect("bp", 5);
        request(1'b1, 16'h5A5A);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hold_data", 32'(bus.rsp_data), 32'hBEEF);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_no_enable", 32'(bus.blk_enable), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        check("bp_released", 32'(bus.rsp_valid), 32'd0);
        check("bp_ready_back", 32'(bus.req_ready), 32'd1);
        check("bp_not_yet", 32'(bus.blk_enable), 32'd0);
        push(16'h0000, 1'b0);
        step();
        bus.req_valid = 1'b0;
        check("bp2_enable", 32'(bus.blk_enable), 32'd1);
        check("bp2_data_in", 32'(bus.blk_data_in), 32'h5A5A);
        bus.blk_ack = 1'b1;
        collect("bp2", 10);
        bus.blk_ack = 1'b0;
        step();

        // asynchronous reset while in WAIT
        request(1'b0, 16'h0000);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        check("rw_in_wait", 32'(bus.blk_enable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rw_enable_drop", 32'(bus.blk_enable), 32'd0);
        check("rw_req_ready", 32'(bus.req_ready), 32'd1);
        check("rw_no_rsp", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rw_silent", 32'(bus.rsp_valid), 32'd0);
        end
        request(1'b0, 16'h0000);
        push(16'h7E81, 1'b0);
        step();
        bus.req_valid = 1'b0;
        bus.blk_data_out = 16'h7E81;
        bus.blk_ack = 1'b1;
        collect("rw_next", 10);
        bus.blk_ack = 1'b0;
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
